// File: rtl/reg_module_pkg.sv
// Shared defaults for the AXI-Stream register slice: data width and
// occupancy-state encoding.
package reg_module_pkg;

    localparam int DEFAULT_DW = 32;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/reg_module_if.sv
// AXI-Stream upstream/downstream bundle around the register slice.
// master = stream source and sink environment, slave = the slice itself.
interface reg_module_if import reg_module_pkg::*; #(parameter int DW = DEFAULT_DW);

    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic          m_ready;
    logic          m_valid;
    logic          m_last;
    logic [DW-1:0] m_data;

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_valid, m_last, m_data
    );

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_valid, m_last, m_data
    );

endinterface

// File: rtl/reg_module.sv
// Full-throughput AXI-Stream register slice: a main register feeding the
// output plus one skid register, with every output taken straight from a flop.
module reg_module import reg_module_pkg::*; #(
    parameter int DW = DEFAULT_DW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    input  logic          m_ready,
    output logic          m_valid,
    output logic          m_last,
    output logic [DW-1:0] m_data
);

    logic [1:0]    state, state_nx;
    logic [DW-1:0] skid_data;
    logic          skid_last;
    logic          accept;
    logic          load_in, load_skid, fill_skid;

    assign accept = s_valid & s_ready;

    always_comb begin
        state_nx  = state;
        load_in   = 1'b0;
        load_skid = 1'b0;
        fill_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nx = ST_ONE;
                    load_in  = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && m_ready) begin
                    load_in = 1'b1;
                end else if (accept) begin
                    // Output is stalled: park the new beat behind it.
                    state_nx  = ST_FULL;
                    fill_skid = 1'b1;
                end else if (m_ready) begin
                    state_nx = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (m_ready) begin
                    state_nx  = ST_ONE;
                    load_skid = 1'b1;
                end
            end
            default: state_nx = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_data <= '0;
            m_last <= 1'b0;
        end else if (load_in) begin
            m_data <= s_data;
            m_last <= s_last;
        end else if (load_skid) begin
            m_data <= skid_data;
            m_last <= skid_last;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            skid_data <= '0;
            skid_last <= 1'b0;
        end else if (fill_skid) begin
            skid_data <= s_data;
            skid_last <= s_last;
        end
    end

    // Handshake flags are registered copies of the next occupancy.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_EMPTY;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            state   <= state_nx;
            s_ready <= (state_nx != ST_FULL);
            m_valid <= (state_nx != ST_EMPTY);
        end
    end

endmodule

// File: tb/tb_reg_module.sv
// Self-checking bench for reg_module: a queue of in-flight beats serves as the
// reference; occupancy, handshakes and output beats are derived from it.
module tb_reg_module;
    import reg_module_pkg::*;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    reg_module_if #(.DW(DW)) bus ();

    reg_module #(.DW(DW)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .s_data  (bus.s_data),
        .s_valid (bus.s_valid),
        .s_last  (bus.s_last),
        .s_ready (bus.s_ready),
        .m_ready (bus.m_ready),
        .m_valid (bus.m_valid),
        .m_last  (bus.m_last),
        .m_data  (bus.m_data)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Beats accepted but not yet delivered, stored as {last, data}.
    logic [DW:0] q[$];

    task automatic test_reset();
        resetn      = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        #10;
        chk_cnt++;
        if (bus.m_valid !== 1'b0 || bus.m_last !== 1'b0 || bus.m_data !== '0 || bus.s_ready !== 1'b0)
            $display("FAIL reset_outputs: got v=%b l=%b d=%h rdy=%b exp all zero",
                     bus.m_valid, bus.m_last, bus.m_data, bus.s_ready);
        else pass_cnt++;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (bus.s_ready !== 1'b1 || bus.m_valid !== 1'b0)
            $display("FAIL reset_release: got rdy=%b v=%b exp rdy=1 v=0", bus.s_ready, bus.m_valid);
        else pass_cnt++;
        q.delete();
    endtask

    // Generic packet run: beats offered in order, optional random gaps on
    // s_valid and random m_ready; every cycle compared against the queue model.
    task automatic test_stream(input string name, input int n, input bit rnd_ready,
                               input bit rnd_valid);
        logic [DW:0] src[$];
        int cyc  = 0;
        int outs = 0;
        int errs = 0;
        for (int i = 0; i < n; i++) src.push_back({1'(i == n - 1), 32'($urandom())});
        while ((src.size() > 0 || q.size() > 0) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            chk_cnt++;
            if (bus.m_valid !== (q.size() > 0) || bus.s_ready !== (q.size() < 2)) begin
                errs++;
                $display("FAIL %s_handshake: cyc %0d got v=%b rdy=%b exp v=%b rdy=%b",
                         name, cyc, bus.m_valid, bus.s_ready, q.size() > 0, q.size() < 2);
            end else pass_cnt++;
            if (q.size() > 0) begin
                chk_cnt++;
                if ({bus.m_last, bus.m_data} !== q[0]) begin
                    errs++;
                    $display("FAIL %s_beat: cyc %0d got l=%b d=%h exp l=%b d=%h",
                             name, cyc, bus.m_last, bus.m_data, q[0][DW], q[0][DW-1:0]);
                end else pass_cnt++;
            end
            bus.m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (src.size() > 0 && (!rnd_valid || src.size() == 1 || $urandom_range(0, 2) != 0)) begin
                bus.s_valid = 1'b1;
                {bus.s_last, bus.s_data} = src[0];
            end else begin
                bus.s_valid = 1'b0;
                bus.s_last  = 1'($urandom_range(0, 1));
                bus.s_data  = $urandom();
            end
            if (bus.m_valid && bus.m_ready) begin
                if (q.size() > 0) void'(q.pop_front());
                outs++;
            end
            if (bus.s_valid && bus.s_ready) q.push_back(src.pop_front());
        end
        chk_cnt++;
        if (outs !== n || cyc >= 300)
            $display("FAIL %s_count: got %0d beats in %0d cycles exp %0d beats", name, outs, cyc, n);
        else pass_cnt++;
        if (!rnd_ready && !rnd_valid) begin
            chk_cnt++;
            if (cyc !== n + 1)
                $display("FAIL %s_throughput: got %0d cycles exp %0d", name, cyc, n + 1);
            else pass_cnt++;
        end
        if (errs != 0) q.delete();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a, b;
        a = $urandom();
        b = $urandom();
        @(negedge clk);
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = a;
        bus.s_last  = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== a || bus.s_ready !== 1'b1)
            $display("FAIL bp_first: got v=%b d=%h rdy=%b exp v=1 d=%h rdy=1",
                     bus.m_valid, bus.m_data, bus.s_ready, a);
        else pass_cnt++;
        bus.s_data = b;
        bus.s_last = 1'b1;
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data  = ~b;
        chk_cnt++;
        if (bus.s_ready !== 1'b0 || bus.m_data !== a || bus.m_last !== 1'b0)
            $display("FAIL bp_full: got rdy=%b d=%h l=%b exp rdy=0 d=%h l=0",
                     bus.s_ready, bus.m_data, bus.m_last, a);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== a || bus.s_ready !== 1'b0)
            $display("FAIL bp_hold: got v=%b d=%h rdy=%b exp v=1 d=%h rdy=0",
                     bus.m_valid, bus.m_data, bus.s_ready, a);
        else pass_cnt++;
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== b || bus.m_last !== 1'b1 || bus.s_ready !== 1'b1)
            $display("FAIL bp_skid_out: got v=%b d=%h l=%b rdy=%b exp v=1 d=%h l=1 rdy=1",
                     bus.m_valid, bus.m_data, bus.m_last, bus.s_ready, b);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (bus.m_valid !== 1'b0 || bus.s_ready !== 1'b1)
            $display("FAIL bp_drain: got v=%b rdy=%b exp v=0 rdy=1", bus.m_valid, bus.s_ready);
        else pass_cnt++;
    endtask

    task automatic test_reset_full();
        @(negedge clk);
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = $urandom();
        bus.s_last  = 1'b0;
        @(negedge clk);
        bus.s_data = $urandom();
        @(negedge clk);
        bus.s_valid = 1'b0;
        chk_cnt++;
        if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b1)
            $display("FAIL rst_full_setup: got rdy=%b v=%b exp rdy=0 v=1", bus.s_ready, bus.m_valid);
        else pass_cnt++;
        #2 resetn = 1'b0;
        #1;
        chk_cnt++;
        if (bus.m_valid !== 1'b0 || bus.m_data !== '0 || bus.s_ready !== 1'b0)
            $display("FAIL rst_async: got v=%b d=%h rdy=%b exp v=0 d=0 rdy=0",
                     bus.m_valid, bus.m_data, bus.s_ready);
        else pass_cnt++;
        @(negedge clk);
        resetn      = 1'b1;
        bus.m_ready = 1'b1;
        q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_cnt++;
            if (bus.m_valid !== 1'b0)
                $display("FAIL rst_stale: cyc %0d got v=%b d=%h exp v=0", i, bus.m_valid, bus.m_data);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_stream("stream", 11, 1'b0, 1'b0);
        test_backpressure();
        test_stream("rand_ready", 11, 1'b1, 1'b0);
        test_stream("gaps", 6, 1'b0, 1'b1);
        test_stream("mixed", 20, 1'b1, 1'b1);
        test_reset_full();
        test_stream("post_reset", 5, 1'b1, 1'b1);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/reg_module.md
REG_MODULE -- requirements
Module: reg_module

Interface
REQ-001 Parameter: DW, default 32, data width of s_data/m_data in bits.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port resetn  input  1  one clock; reset is asynchronous and active-low.
REQ-004 Port s_data  input  DW  upstream AXI-Stream data (tdata).
REQ-005 Port s_valid  input  1  upstream beat valid (tvalid).
REQ-006 Port s_last  input  1  upstream end-of-packet marker (tlast).
REQ-007 Port s_ready  output  1  block can accept an upstream beat (tready).
REQ-008 Port m_ready  input  1  downstream ready (tready).
REQ-009 Port m_valid  output  1  downstream beat valid (tvalid).
REQ-010 Port m_last  output  1  downstream end-of-packet marker (tlast).
REQ-011 Port m_data  output  DW  downstream data (tdata).
REQ-012 Port order SHALL be: clk, resetn, s_data, s_valid, s_last, s_ready, m_ready, m_valid, m_last, m_data.

Function
REQ-013 Block SHALL be a full-throughput AXI-Stream register slice (skid buffer): main register plus one skid register, each holding {data, last}.
REQ-014 Upstream transfer SHALL occur on a rising edge with s_valid=1 and s_ready=1; downstream transfer on a rising edge with m_valid=1 and m_ready=1.
REQ-015 All outputs (s_ready, m_valid, m_data, m_last) SHALL be driven directly from flops; no combinational input-to-output path.
REQ-016 Occupancy states SHALL be EMPTY (0 beats), ONE (main valid), FULL (main and skid valid).
REQ-017 EMPTY: accept -> ONE, beat loaded into main; m_valid=1 the next cycle (1-cycle latency).
REQ-018 ONE: accept with m_ready=1 -> stay ONE, main reloaded with new beat; accept with m_ready=0 -> FULL, beat into skid; no accept with m_ready=1 -> EMPTY; no accept with m_ready=0 -> hold.
REQ-019 FULL: m_ready=1 -> ONE, skid moved to main; m_ready=0 -> hold; no upstream accept in FULL.
REQ-020 s_ready SHALL be 1 in EMPTY and ONE, 0 in FULL (registered, updated on the edge that changes state).
REQ-021 m_valid SHALL be 1 in ONE and FULL; m_data/m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-022 Beats SHALL leave in acceptance order; s_last SHALL travel with its data unaltered; no beat dropped or duplicated.
REQ-023 With m_ready held 1 and s_valid held 1, throughput SHALL be one beat per cycle.
REQ-024 m_valid SHALL never depend on m_ready; a beat once presented is held until accepted.
REQ-025 s_data/s_last SHALL be ignored (not captured) when s_valid=0 or s_ready=0.

Reset
REQ-026 resetn=0 SHALL asynchronously force EMPTY: m_valid=0, m_last=0, m_data=0, skid cleared, s_ready=0.
REQ-027 s_ready SHALL rise to 1 on the first rising edge with resetn=1; reset mid-packet SHALL discard all held beats.

Structure
REQ-028 Default DW and state encoding (EMPTY/ONE/FULL) SHALL live in a shared package, reg_module_pkg.
REQ-029 Single module, no sub-modules; skid and main registers written in one process per register.

Verification
REQ-030 Reset: resetn=0 for 10 ns -> m_valid=0, m_data=0, m_last=0, s_ready=0; first edge after release -> s_ready=1.
REQ-031 Streaming: m_ready=1, 11 beats valid every cycle (last on beat 11) -> 11 beats out in order, 1-cycle latency, m_last only on beat 11.
REQ-032 Backpressure: beat A accepted, m_ready=0, beat B offered -> B in skid, s_ready=0 next cycle, m_data=A stable; m_ready=1 -> A out, then B, s_ready back to 1.
REQ-033 Random m_ready (toggled each cycle) with continuous s_valid, 11-beat packet -> scoreboard matches all data/last, no loss/duplication.
REQ-034 Random s_valid gaps, 6-beat packet, last beat forced valid with s_last=1 -> only valid beats appear, m_last on final beat only.
REQ-035 Reset asserted while FULL -> m_valid=0 immediately (asynchronous), no stale beat after release.
